// File: rtl/oam_dma_controller.sv
// OAM DMA sequencer: an FF46 write copies DMA_LEN bytes from {page,00h} into OAM,
// one byte per CYCLES_PER_BYTE clocks, after a START_DELAY clock lead-in.
module oam_dma_controller #(
  parameter int unsigned DMA_LEN         = 160,
  parameter int unsigned CYCLES_PER_BYTE = 4,
  parameter int unsigned START_DELAY     = 4
) (
  input  logic        i_clk,
  input  logic        i_reset_n,
  input  logic        i_reg_we,
  input  logic [7:0]  i_reg_wdata,
  output logic [7:0]  o_reg_rdata,
  output logic        o_src_rd_en,
  output logic [15:0] o_src_addr,
  input  logic [7:0]  i_src_rdata,
  output logic        o_oam_we,
  output logic [7:0]  o_oam_addr,
  output logic [7:0]  o_oam_wdata,
  output logic        o_dma_active,
  output logic        o_dma_done
);

  localparam int unsigned XFER_CYCLES = DMA_LEN * CYCLES_PER_BYTE;
  localparam int unsigned DW          = $clog2(START_DELAY + 1);
  localparam int unsigned XW          = $clog2(XFER_CYCLES);

  localparam logic [DW-1:0] DLAST = DW'(START_DELAY - 1);
  localparam logic [DW-1:0] DONE  = DW'(1);
  localparam logic [XW-1:0] XLAST = XW'(XFER_CYCLES - 1);
  localparam logic [XW-1:0] XONE  = XW'(1);
  localparam logic [XW-1:0] XCPB  = XW'(CYCLES_PER_BYTE);

  typedef enum logic [1:0] {StIdle, StStart, StXfer} state_e;

  state_e          r_state, w_state_d;
  logic [7:0]      r_page, w_page_d;
  logic [DW-1:0]   r_dcnt, w_dcnt_d;
  logic [XW-1:0]   r_xcnt, w_xcnt_d;
  logic            r_from_xfer, w_from_xfer_d;
  logic            r_done, w_done_d;

  logic [XW-1:0]   w_ph;
  logic [7:0]      w_idx;
  logic [7:0]      w_effpage;

  assign w_ph      = r_xcnt % XCPB;
  assign w_idx     = 8'(r_xcnt / XCPB);
  // E0..FF pages alias onto C0..DF (echo RAM)
  assign w_effpage = (r_page >= 8'hE0) ? (r_page - 8'h20) : r_page;

  always_ff @(posedge i_clk or negedge i_reset_n) begin
    if (!i_reset_n) begin
      r_state     <= StIdle;
      r_page      <= 8'hFF;
      r_dcnt      <= '0;
      r_xcnt      <= '0;
      r_from_xfer <= 1'b0;
      r_done      <= 1'b0;
    end else begin
      r_state     <= w_state_d;
      r_page      <= w_page_d;
      r_dcnt      <= w_dcnt_d;
      r_xcnt      <= w_xcnt_d;
      r_from_xfer <= w_from_xfer_d;
      r_done      <= w_done_d;
    end
  end

  always_comb begin
    w_state_d     = r_state;
    w_page_d      = r_page;
    w_dcnt_d      = r_dcnt;
    w_xcnt_d      = r_xcnt;
    w_from_xfer_d = r_from_xfer;
    w_done_d      = 1'b0;
    if (i_reg_we) begin
      // A write always (re)launches; a relaunch out of an active copy keeps dma_active high
      w_page_d      = i_reg_wdata;
      w_state_d     = StStart;
      w_dcnt_d      = '0;
      w_xcnt_d      = '0;
      w_from_xfer_d = (r_state == StXfer) || ((r_state == StStart) && r_from_xfer);
    end else begin
      case (r_state)
        StIdle: ;
        StStart: begin
          if (r_dcnt == DLAST) begin
            w_state_d     = StXfer;
            w_dcnt_d      = '0;
            w_xcnt_d      = '0;
            w_from_xfer_d = 1'b0;
          end else begin
            w_dcnt_d = r_dcnt + DONE;
          end
        end
        StXfer: begin
          if (r_xcnt == XLAST) begin
            w_state_d = StIdle;
            w_xcnt_d  = '0;
            w_done_d  = 1'b1;
          end else begin
            w_xcnt_d = r_xcnt + XONE;
          end
        end
        default: w_state_d = StIdle;
      endcase
    end
  end

  always_comb begin
    o_src_rd_en  = 1'b0;
    o_src_addr   = 16'h0000;
    o_oam_we     = 1'b0;
    o_oam_addr   = 8'h00;
    o_oam_wdata  = 8'h00;
    o_dma_active = (r_state == StXfer) || ((r_state == StStart) && r_from_xfer);
    if (r_state == StXfer) begin
      if (w_ph == '0) begin
        o_src_rd_en = 1'b1;
        o_src_addr  = {w_effpage, w_idx};
      end else if (w_ph == XONE) begin
        o_oam_we    = 1'b1;
        o_oam_addr  = w_idx;
        o_oam_wdata = i_src_rdata;
      end
    end
  end

  assign o_reg_rdata = r_page;
  assign o_dma_done  = r_done;

endmodule

// File: tb/tb_oam_dma_controller.sv
// Directed bench for oam_dma_controller: table of full transfers plus restart,
// final-cycle collision and asynchronous reset sequences.
module tb_oam_dma_controller;

  logic        clk = 1'b0;
  logic        reset_n;
  logic        reg_we;
  logic [7:0]  reg_wdata;
  logic [7:0]  reg_rdata;
  logic        src_rd_en;
  logic [15:0] src_addr;
  logic [7:0]  src_rdata;
  logic        oam_we;
  logic [7:0]  oam_addr;
  logic [7:0]  oam_wdata;
  logic        dma_active;
  logic        dma_done;

  oam_dma_controller dut (
    .i_clk       (clk),
    .i_reset_n   (reset_n),
    .i_reg_we    (reg_we),
    .i_reg_wdata (reg_wdata),
    .o_reg_rdata (reg_rdata),
    .o_src_rd_en (src_rd_en),
    .o_src_addr  (src_addr),
    .i_src_rdata (src_rdata),
    .o_oam_we    (oam_we),
    .o_oam_addr  (oam_addr),
    .o_oam_wdata (oam_wdata),
    .o_dma_active(dma_active),
    .o_dma_done  (dma_done)
  );

  always #5 clk = ~clk;

  logic [7:0] mem [0:65535];
  logic [7:0] oam [0:255];

  // Source memory with one clock of read latency, and the OAM array itself
  always @(posedge clk) begin
    if (src_rd_en) src_rdata <= mem[src_addr];
    if (oam_we) oam[oam_addr] <= oam_wdata;
  end

  localparam int MAXK = 2048;
  logic        s_rd    [0:MAXK-1];
  logic [15:0] s_addr  [0:MAXK-1];
  logic        s_we    [0:MAXK-1];
  logic [7:0]  s_oaddr [0:MAXK-1];
  logic [7:0]  s_wdata [0:MAXK-1];
  logic        s_act   [0:MAXK-1];
  logic        s_done  [0:MAXK-1];
  logic [7:0]  s_rb    [0:MAXK-1];

  int n_chk  = 0;
  int n_fail = 0;

  typedef struct {
    logic [7:0] page;
    logic [7:0] eff;
    logic [7:0] seed;
  } vec_t;

  vec_t tbl [0:4];

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  task automatic preload(input logic [7:0] eff, input logic [7:0] seed);
    for (int i = 0; i < 160; i++) mem[{eff, 8'(i)}] = 8'(i) ^ seed;
    for (int i = 0; i < 256; i++) oam[i] = 8'h00;
  endtask

  // One-clock FF46 write; returns at the negedge of the first cycle after the write edge
  task automatic launch(input logic [7:0] pg);
    @(negedge clk);
    reg_we    = 1'b1;
    reg_wdata = pg;
    @(negedge clk);
    reg_we    = 1'b0;
  endtask

  // Record outputs for ncyc cycles; optionally write we_pg during cycle we_k
  task automatic capture(input int ncyc, input int we_k, input logic [7:0] we_pg);
    for (int k = 0; k < ncyc; k++) begin
      s_rd[k]    = src_rd_en;
      s_addr[k]  = src_addr;
      s_we[k]    = oam_we;
      s_oaddr[k] = oam_addr;
      s_wdata[k] = oam_wdata;
      s_act[k]   = dma_active;
      s_done[k]  = dma_done;
      s_rb[k]    = reg_rdata;
      reg_we     = (k == we_k);
      reg_wdata  = we_pg;
      @(negedge clk);
    end
    reg_we = 1'b0;
  endtask

  // Check one complete transfer whose write edge ended cycle k0-1
  task automatic check_xfer(input string nm, input int k0, input int ncap, input logic [7:0] pg,
                            input logic [7:0] eff, input logic [7:0] seed, input int act_exp);
    int nrd = 0, nwe = 0, rd_err = 0, we_err = 0, ndone = 0, kdone = -1, nact = 0, rb_err = 0;
    int oam_err = 0;
    int kend = k0 + 700;
    if (kend > ncap) kend = ncap;
    for (int k = k0; k < kend; k++) begin
      if (s_rd[k]) begin
        if (k != k0 + 4 + 4 * nrd || s_addr[k] != {eff, 8'(nrd)}) rd_err++;
        nrd++;
      end
      if (s_we[k]) begin
        if (k != k0 + 5 + 4 * nwe || s_oaddr[k] != 8'(nwe) || s_wdata[k] != (8'(nwe) ^ seed))
          we_err++;
        nwe++;
      end
      if (s_done[k]) begin
        ndone++;
        kdone = k;
      end
      if (s_rb[k] != pg) rb_err++;
    end
    for (int k = k0; k < k0 + 645; k++) if (s_act[k]) nact++;
    for (int i = 0; i < 160; i++) if (oam[i] != (8'(i) ^ seed)) oam_err++;
    chk({nm, " reads"}, 64'(nrd), 64'd160);
    chk({nm, " read_addr_err"}, 64'(rd_err), 64'd0);
    chk({nm, " writes"}, 64'(nwe), 64'd160);
    chk({nm, " write_err"}, 64'(we_err), 64'd0);
    chk({nm, " done_count"}, 64'(ndone), 64'd1);
    chk({nm, " done_cycle"}, 64'(kdone), 64'(k0 + 644));
    chk({nm, " active_cycles"}, 64'(nact), 64'(act_exp));
    chk({nm, " readback_err"}, 64'(rb_err), 64'd0);
    chk({nm, " oam_content_err"}, 64'(oam_err), 64'd0);
  endtask

  initial begin
    int cnt, cnt2;
    tbl[0] = '{page: 8'hC1, eff: 8'hC1, seed: 8'h5A};
    tbl[1] = '{page: 8'hFE, eff: 8'hDE, seed: 8'h33};
    tbl[2] = '{page: 8'h00, eff: 8'h00, seed: 8'hA5};
    tbl[3] = '{page: 8'hE0, eff: 8'hC0, seed: 8'h0F};
    tbl[4] = '{page: 8'hDF, eff: 8'hDF, seed: 8'hC3};

    for (int a = 0; a < 65536; a++) mem[a] = 8'h00;
    reset_n   = 1'b0;
    reg_we    = 1'b0;
    reg_wdata = 8'h00;
    src_rdata = 8'h00;
    repeat (3) @(negedge clk);
    chk("reset reg_rdata", 64'(reg_rdata), 64'hFF);
    chk("reset outputs", {src_rd_en, oam_we, dma_active, dma_done, src_addr, oam_addr, oam_wdata},
        64'd0);
    reset_n = 1'b1;
    repeat (3) @(negedge clk);
    chk("idle reg_rdata", 64'(reg_rdata), 64'hFF);
    chk("idle dma_active", 64'(dma_active), 64'd0);

    for (int v = 0; v < 5; v++) begin
      preload(tbl[v].eff, tbl[v].seed);
      launch(tbl[v].page);
      capture(700, -1, 8'h00);
      check_xfer($sformatf("xfer_%02h", tbl[v].page), 0, 700, tbl[v].page, tbl[v].eff,
                 tbl[v].seed, 640);
    end

    // Restart: D0h written during byte 50 phase 2 (cycle 206)
    preload(8'hC1, 8'h5A);
    preload(8'hD0, 8'h69);
    launch(8'hC1);
    capture(910, 206, 8'hD0);
    cnt = 0;
    for (int k = 205; k < 910; k++) if (s_rd[k] && s_addr[k][15:8] == 8'hC1) cnt++;
    chk("restart stale_reads", 64'(cnt), 64'd0);
    cnt = 0;
    for (int k = 4; k < 851; k++) if (s_act[k]) cnt++;
    chk("restart active_continuous", 64'(cnt), 64'd847);
    cnt = 0;
    for (int k = 0; k < 207; k++) if (s_done[k]) cnt++;
    chk("restart old_done", 64'(cnt), 64'd0);
    check_xfer("restart_d0", 207, 910, 8'hD0, 8'hD0, 8'h69, 644);

    // Collision: C2h written on the final XFER cycle (xcnt 639 = cycle 643)
    preload(8'hC1, 8'h5A);
    preload(8'hC2, 8'h96);
    launch(8'hC1);
    capture(1350, 643, 8'hC2);
    cnt  = 0;
    cnt2 = 0;
    for (int k = 0; k < 645; k++) if (s_done[k]) cnt++;
    for (int k = 4; k < 644; k++) if (s_act[k]) cnt2++;
    chk("collision old_done", 64'(cnt), 64'd0);
    chk("collision active_first", 64'(cnt2), 64'd640);
    chk("collision first_new_read", {s_rd[648], s_addr[648]}, {1'b1, 16'hC200});
    check_xfer("collision_c2", 644, 1350, 8'hC2, 8'hC2, 8'h96, 644);

    // Asynchronous reset at byte 80 phase 0 (cycle 324)
    preload(8'hC1, 8'h5A);
    launch(8'hC1);
    repeat (324) @(negedge clk);
    chk("midreset pre_read", {src_rd_en, src_addr}, {1'b1, 16'hC150});
    reset_n = 1'b0;
    #1;
    chk("midreset outputs", {src_rd_en, oam_we, dma_active, dma_done, src_addr, oam_addr,
        oam_wdata}, 64'd0);
    chk("midreset reg_rdata", 64'(reg_rdata), 64'hFF);
    @(negedge clk);
    reset_n = 1'b1;
    capture(700, -1, 8'h00);
    cnt  = 0;
    cnt2 = 0;
    for (int k = 0; k < 700; k++) begin
      if (s_rd[k] || s_we[k] || s_act[k] || s_done[k]) cnt++;
      if (s_rb[k] != 8'hFF) cnt2++;
    end
    chk("postreset activity", 64'(cnt), 64'd0);
    chk("postreset readback_err", 64'(cnt2), 64'd0);
    chk("postreset kept_oam", 64'(oam[79]), 64'(8'd79 ^ 8'h5A));

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
